// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the CPU memory-bus and OAM DMA logic.
package gb_cpu_common_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int          OAM_LEN      = 160;
  localparam logic [7:0]  HIGH_PAGE    = 8'hFF;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER
  } dma_state_t;

  typedef enum logic [1:0] {
    REGION_MEM,
    REGION_IO,
    REGION_DMA_REG
  } addr_region_t;

  // Pages E0-FF are the echo of C0-DF; the DMA reads echo pages from work RAM.
  function automatic logic [7:0] dma_eff_src(input logic [7:0] src);
    return (src >= 8'hE0) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/gb_dma_bus_router.sv
// CPU address region decode and CPU/DMA steering onto the mem_*, io_* and read-data paths.
// GB_DMA_BUS_CONFLICT_EN: blocked CPU reads return the byte the DMA is reading (else 8'hFF).
module gb_dma_bus_router #(
  parameter logic [15:0] DMA_REG_ADDR = gb_cpu_common_pkg::DMA_REG_ADDR
) (
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_wr_i,
  output logic [7:0]  cpu_data_o,
  input  logic        cpu_blocked_i,
  input  logic        dma_rd_i,
  input  logic [15:0] dma_addr_i,
  input  logic [7:0]  src_reg_i,
  output gb_cpu_common_pkg::addr_region_t region_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_data_o,
  output logic        mem_wr_o,
  input  logic [7:0]  mem_data_i,
  output logic [7:0]  io_addr_o,
  output logic [7:0]  io_data_o,
  output logic        io_wr_o,
  input  logic [7:0]  io_data_i
);
  import gb_cpu_common_pkg::*;

  logic [7:0] blocked_rd;

`ifdef GB_DMA_BUS_CONFLICT_EN
  assign blocked_rd = mem_data_i;
`else
  assign blocked_rd = 8'hFF;
`endif

  always_comb begin
    region_o = REGION_MEM;
    if (cpu_addr_i == DMA_REG_ADDR) begin
      region_o = REGION_DMA_REG;
    end else if (cpu_addr_i[15:8] == HIGH_PAGE) begin
      region_o = REGION_IO;
    end
  end

  assign io_addr_o  = cpu_addr_i[7:0];
  assign io_data_o  = cpu_data_i;
  assign io_wr_o    = cpu_wr_i && (region_o == REGION_IO);

  assign mem_addr_o = dma_rd_i ? dma_addr_i : cpu_addr_i;
  assign mem_data_o = cpu_data_i;
  assign mem_wr_o   = cpu_wr_i && (region_o == REGION_MEM) && !cpu_blocked_i;

  always_comb begin
    cpu_data_o = mem_data_i;
    case (region_o)
      REGION_DMA_REG: cpu_data_o = src_reg_i;
      REGION_IO:      cpu_data_o = io_data_i;
      default:        cpu_data_o = cpu_blocked_i ? blocked_rd : mem_data_i;
    endcase
  end

endmodule

// File: rtl/gb_oam_dma_ctrl.sv
// OAM DMA engine: FF46 write copies 160 bytes from {src,00} into OAM, one per M-cycle.
// Blocked CPU read data is selected by GB_DMA_BUS_CONFLICT_EN (see gb_dma_bus_router).
//
// state     | meaning
// ----------+---------------------------------------------------------------
// DMA_IDLE  | CPU owns the main bus
// DMA_START | START_DELAY cycles before the first byte; CPU blocked on restart
// DMA_XFER  | one byte per cycle from {eff_src, idx} to OAM[idx]; CPU blocked
module gb_oam_dma_ctrl #(
  parameter int          OAM_LEN      = gb_cpu_common_pkg::OAM_LEN,
  parameter logic [15:0] DMA_REG_ADDR = gb_cpu_common_pkg::DMA_REG_ADDR,
  parameter int          START_DELAY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_wr_i,
  output logic [7:0]  cpu_data_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_data_o,
  output logic        mem_wr_o,
  input  logic [7:0]  mem_data_i,
  output logic [7:0]  io_addr_o,
  output logic [7:0]  io_data_o,
  output logic        io_wr_o,
  input  logic [7:0]  io_data_i,
  output logic [7:0]  oam_addr_o,
  output logic [7:0]  oam_data_o,
  output logic        oam_wr_o,
  output logic        dma_active_o
);
  import gb_cpu_common_pkg::*;

  localparam int               CNT_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(START_DELAY - 1);
  localparam logic [7:0]       IDX_LAST = 8'(OAM_LEN - 1);

  dma_state_t       state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blk_q, blk_d;

  addr_region_t     region;
  logic             reg_wr;
  logic             cpu_blocked;
  logic             dma_rd;
  logic [15:0]      dma_addr;

  assign reg_wr      = cpu_wr_i && (region == REGION_DMA_REG);
  assign dma_rd      = (state_q == DMA_XFER);
  assign cpu_blocked = dma_rd || ((state_q == DMA_START) && blk_q);
  assign dma_addr    = {dma_eff_src(src_q), idx_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    if (reg_wr) begin
      src_d = cpu_data_i;
    end
    case (state_q)
      DMA_IDLE: begin
        if (reg_wr) begin
          state_d = DMA_START;
          cnt_d   = CNT_LOAD;
          blk_d   = 1'b0;
        end
      end
      DMA_START: begin
        if (reg_wr) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = DMA_XFER;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DMA_XFER: begin
        // A restart wins over the terminal count; the current byte still lands.
        if (reg_wr) begin
          state_d = DMA_START;
          cnt_d   = CNT_LOAD;
          blk_d   = 1'b1;
          idx_d   = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = DMA_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      default: begin
        state_d = DMA_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DMA_IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

  assign oam_addr_o   = idx_q;
  assign oam_data_o   = mem_data_i;
  assign oam_wr_o     = dma_rd;
  assign dma_active_o = (state_q != DMA_IDLE);

  gb_dma_bus_router #(
    .DMA_REG_ADDR (DMA_REG_ADDR)
  ) u_router (
    .cpu_addr_i    (cpu_addr_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_wr_i      (cpu_wr_i),
    .cpu_data_o    (cpu_data_o),
    .cpu_blocked_i (cpu_blocked),
    .dma_rd_i      (dma_rd),
    .dma_addr_i    (dma_addr),
    .src_reg_i     (src_q),
    .region_o      (region),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_wr_o      (mem_wr_o),
    .mem_data_i    (mem_data_i),
    .io_addr_o     (io_addr_o),
    .io_data_o     (io_data_o),
    .io_wr_o       (io_wr_o),
    .io_data_i     (io_data_i)
  );

endmodule

// File: tb/tb_gb_oam_dma_ctrl.sv
// Directed bench for gb_oam_dma_ctrl with a behavioural main memory and FFxx register file.
module tb_gb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_data_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic        mem_wr_o;
  logic [7:0]  mem_data_i;
  logic [7:0]  io_addr_o;
  logic [7:0]  io_data_o;
  logic        io_wr_o;
  logic [7:0]  io_data_i;
  logic [7:0]  oam_addr_o;
  logic [7:0]  oam_data_o;
  logic        oam_wr_o;
  logic        dma_active_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem    [0:65535];
  logic [7:0] io_mem [0:255];
  bit         preload_done = 1'b0;

  always #5 clk = ~clk;

  gb_oam_dma_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr_i   (cpu_addr),
    .cpu_data_i   (cpu_dout),
    .cpu_wr_i     (cpu_wr),
    .cpu_data_o   (cpu_data_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_wr_o     (mem_wr_o),
    .mem_data_i   (mem_data_i),
    .io_addr_o    (io_addr_o),
    .io_data_o    (io_data_o),
    .io_wr_o      (io_wr_o),
    .io_data_i    (io_data_i),
    .oam_addr_o   (oam_addr_o),
    .oam_data_o   (oam_data_o),
    .oam_wr_o     (oam_wr_o),
    .dma_active_o (dma_active_o)
  );

  assign mem_data_i = mem[mem_addr_o];
  assign io_data_i  = io_mem[io_addr_o];

  // Preload happens on the first edge, while reset is still held.
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      for (int i = 0; i < 160; i++) begin
        mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
        mem[16'hC100 + i] = 8'(i) + 8'h03;
        mem[16'hD000 + i] = 8'(i) ^ 8'hA5;
      end
      mem[16'h1234] = 8'h77;
      mem[16'h0150] = 8'hB7;
      preload_done = 1'b1;
    end else if (mem_wr_o) begin
      mem[mem_addr_o] = mem_data_o;
    end
  end

  always @(posedge clk) begin
    if (io_wr_o) io_mem[io_addr_o] = io_data_o;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic [15:0] a, input logic [7:0] d, input logic w);
    cpu_addr = a;
    cpu_dout = d;
    cpu_wr   = w;
  endtask

  logic [7:0] blk_exp;

  initial begin
    for (int i = 0; i < 256; i++) io_mem[i] = 8'h00;
    reset = 1'b0;
    cpu(16'h0000, 8'h00, 1'b0);
    #2;
    chk("rst_dma_active", 16'(dma_active_o), 16'h0);
    chk("rst_oam_wr", 16'(oam_wr_o), 16'h0);
    chk("rst_mem_wr", 16'(mem_wr_o), 16'h0);
    chk("rst_io_wr", 16'(io_wr_o), 16'h0);
    cpu(16'hFF46, 8'h00, 1'b0);
    #1;
    chk("rst_src_reg", 16'(cpu_data_o), 16'h00);
    cyc();
    cyc();
    reset = 1'b1;

    // CPU owns the bus in IDLE
    cyc();
    cpu(16'h1234, 8'h00, 1'b0);
    #3;
    chk("idle_mem_addr", mem_addr_o, 16'h1234);
    chk("idle_rd", 16'(cpu_data_o), 16'h77);
    cyc();
    cpu(16'hC200, 8'h3C, 1'b1);
    #3;
    chk("idle_mem_wr", 16'(mem_wr_o), 16'h1);
    chk("idle_mem_wdata", 16'(mem_data_o), 16'h3C);

    // 1. basic copy from C000
    cyc();
    cpu(16'hFF46, 8'hC0, 1'b1);
    #3;
    chk("t1_io_wr_ff46", 16'(io_wr_o), 16'h0);
    chk("t1_active_T", 16'(dma_active_o), 16'h0);
    cyc();
    cpu(16'h0000, 8'h00, 1'b0);
    #3;
    chk("t1_start_active", 16'(dma_active_o), 16'h1);
    chk("t1_start_no_oam", 16'(oam_wr_o), 16'h0);
    for (int i = 0; i < 160; i++) begin
      cyc();
      #3;
      chk("t1_oam_wr", 16'(oam_wr_o), 16'h1);
      chk("t1_oam_addr", 16'(oam_addr_o), 16'(i));
      chk("t1_oam_data", 16'(oam_data_o), 16'(8'(i) ^ 8'h5A));
      chk("t1_mem_addr", mem_addr_o, {8'hC0, 8'(i)});
      chk("t1_active", 16'(dma_active_o), 16'h1);
    end
    cyc();
    #3;
    chk("t1_active_fall", 16'(dma_active_o), 16'h0);
    chk("t1_oam_wr_end", 16'(oam_wr_o), 16'h0);

    // 2. CPU accesses during XFER
    cyc();
    cpu(16'hFF46, 8'hC0, 1'b1);
    cyc();
    cpu(16'h0000, 8'h00, 1'b0);
    cyc();
    cpu(16'h0150, 8'h00, 1'b0);
`ifdef GB_DMA_BUS_CONFLICT_EN
    blk_exp = 8'h5A;
`else
    blk_exp = 8'hFF;
`endif
    #3;
    chk("t2_mem_addr_dma", mem_addr_o, 16'hC000);
    chk("t2_blocked_rd", 16'(cpu_data_o), 16'(blk_exp));
    cyc();
    cpu(16'hC100, 8'h99, 1'b1);
    #3;
    chk("t2_blocked_wr", 16'(mem_wr_o), 16'h0);
    chk("t2_mem_addr_dma1", mem_addr_o, 16'hC001);
    cyc();
    cpu(16'hFF85, 8'h42, 1'b1);
    #3;
    chk("t2_io_wr", 16'(io_wr_o), 16'h1);
    chk("t2_io_addr", 16'(io_addr_o), 16'h85);
    chk("t2_io_wdata", 16'(io_data_o), 16'h42);
    cyc();
    cpu(16'hFF85, 8'h00, 1'b0);
    #3;
    chk("t2_io_rd", 16'(cpu_data_o), 16'h42);
    cyc();
    cpu(16'hFF46, 8'h00, 1'b0);
    #3;
    chk("t2_ff46_rd", 16'(cpu_data_o), 16'hC0);
    cpu(16'h0000, 8'h00, 1'b0);
    for (int i = 5; i < 160; i++) cyc();
    cyc();
    #3;
    chk("t2_active_fall", 16'(dma_active_o), 16'h0);
    chk("t2_c100_kept", 16'(mem[16'hC100]), 16'h03);

    // 3. echo-RAM source
    cyc();
    cpu(16'hFF46, 8'hE1, 1'b1);
    cyc();
    cpu(16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 160; i++) begin
      cyc();
      #3;
      chk("t3_mem_addr", mem_addr_o, {8'hC1, 8'(i)});
      chk("t3_oam_data", 16'(oam_data_o), 16'(8'(i) + 8'h03));
    end
    cyc();
    cpu(16'hFF46, 8'h00, 1'b0);
    #3;
    chk("t3_ff46_rd", 16'(cpu_data_o), 16'hE1);
    chk("t3_active_fall", 16'(dma_active_o), 16'h0);

    // 4. restart at idx 50
    cyc();
    cpu(16'hFF46, 8'hC0, 1'b1);
    cyc();
    cpu(16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 50; i++) cyc();
    cyc();
    cpu(16'hFF46, 8'hD0, 1'b1);
    #3;
    chk("t4_idx50_wr", 16'(oam_wr_o), 16'h1);
    chk("t4_idx50_addr", 16'(oam_addr_o), 16'd50);
    cyc();
    cpu(16'hC101, 8'h11, 1'b1);
    #3;
    chk("t4_start_no_oam", 16'(oam_wr_o), 16'h0);
    chk("t4_start_active", 16'(dma_active_o), 16'h1);
    chk("t4_start_blocked_wr", 16'(mem_wr_o), 16'h0);
    cpu(16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 160; i++) begin
      cyc();
      #3;
      chk("t4_oam_wr", 16'(oam_wr_o), 16'h1);
      chk("t4_oam_addr", 16'(oam_addr_o), 16'(i));
      chk("t4_oam_data", 16'(oam_data_o), 16'(8'(i) ^ 8'hA5));
      chk("t4_mem_addr", mem_addr_o, {8'hD0, 8'(i)});
      chk("t4_active", 16'(dma_active_o), 16'h1);
    end
    cyc();
    #3;
    chk("t4_active_fall", 16'(dma_active_o), 16'h0);

    // 5. async reset at idx 80
    cyc();
    cpu(16'hFF46, 8'hC0, 1'b1);
    cyc();
    cpu(16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 80; i++) cyc();
    cyc();
    #1;
    chk("t5_pre_oam_addr", 16'(oam_addr_o), 16'd80);
    reset = 1'b0;
    #1;
    chk("t5_rst_oam_wr", 16'(oam_wr_o), 16'h0);
    chk("t5_rst_active", 16'(dma_active_o), 16'h0);
    chk("t5_rst_idx", 16'(oam_addr_o), 16'h0);
    cyc();
    reset = 1'b1;
    cpu(16'hC005, 8'h00, 1'b0);
    #3;
    chk("t5_cpu_mem_addr", mem_addr_o, 16'hC005);
    chk("t5_cpu_rd", 16'(cpu_data_o), 16'h5F);
    chk("t5_active", 16'(dma_active_o), 16'h0);
    cyc();
    cpu(16'hC210, 8'h66, 1'b1);
    #3;
    chk("t5_cpu_mem_wr", 16'(mem_wr_o), 16'h1);
    cyc();
    cpu(16'hFF46, 8'h00, 1'b0);
    #3;
    chk("t5_src_cleared", 16'(cpu_data_o), 16'h00);

    // 6. FF46 write in the final XFER cycle
    cyc();
    cpu(16'hFF46, 8'hC0, 1'b1);
    cyc();
    cpu(16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 159; i++) cyc();
    cyc();
    cpu(16'hFF46, 8'hD0, 1'b1);
    #3;
    chk("t6_last_wr", 16'(oam_wr_o), 16'h1);
    chk("t6_last_addr", 16'(oam_addr_o), 16'd159);
    chk("t6_last_data", 16'(oam_data_o), 16'hC5);
    cyc();
    cpu(16'h0000, 8'h00, 1'b0);
    #3;
    chk("t6_start_no_oam", 16'(oam_wr_o), 16'h0);
    chk("t6_start_active", 16'(dma_active_o), 16'h1);
    for (int i = 0; i < 160; i++) begin
      cyc();
      #3;
      chk("t6_oam_wr", 16'(oam_wr_o), 16'h1);
      chk("t6_oam_addr", 16'(oam_addr_o), 16'(i));
      chk("t6_oam_data", 16'(oam_data_o), 16'(8'(i) ^ 8'hA5));
    end
    cyc();
    #3;
    chk("t6_active_fall", 16'(dma_active_o), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
